// File: rtl/sdp_cacc2sdp_rx_pkg.sv
// Shared constants and payload layout for the CACC-to-SDP receiver.
// Optional perf counters elsewhere are enabled with SDP_CACC_RX_PERF_EN.
package sdp_cacc_rx_pkg;

  localparam int CACC2SDP_PD_W  = 514;
  localparam int ELEM_W         = 32;
  localparam int ELEMS_PER_LINE = 16;
  localparam int BATCH_END_BIT  = 512;
  localparam int LAYER_END_BIT  = 513;

  // Field order puts layerEnd at bit 513, batchEnd at 512, element i at [32i+31:32i].
  typedef struct packed {
    logic                                        layerEnd;
    logic                                        batchEnd;
    logic [ELEMS_PER_LINE-1:0][ELEM_W-1:0]       elems;
  } cacc2sdp_pd_t;

  function automatic int beatsPerLine(input int outElems);
    return ELEMS_PER_LINE / outElems;
  endfunction

endpackage

// File: rtl/sdp_cacc2sdp_rx_if.sv
// Stream bundle between CACC output, the SDP receiver and the SDP datapath.
// Perf counters (SDP_CACC_RX_PERF_EN) are plain ports on the top, not part of this bundle.
interface sdp_cacc2sdp_rx_if
  import sdp_cacc_rx_pkg::*;
#(
  parameter int OUT_ELEMS = 4
) ();

  logic                          cacc2sdp_valid;
  logic                          cacc2sdp_ready;
  logic [CACC2SDP_PD_W-1:0]      cacc2sdp_pd;
  logic                          sdp_dp_valid;
  logic                          sdp_dp_ready;
  logic [ELEM_W*OUT_ELEMS-1:0]   sdp_dp_data;
  logic                          sdp_dp_last;
  logic                          sdp_dp_batch_end;
  logic                          sdp_dp_layer_end;
  logic                          sdp_layer_done;
  logic                          rx_idle;

  modport slave (
    input  cacc2sdp_valid, cacc2sdp_pd, sdp_dp_ready,
    output cacc2sdp_ready, sdp_dp_valid, sdp_dp_data, sdp_dp_last,
           sdp_dp_batch_end, sdp_dp_layer_end, sdp_layer_done, rx_idle
  );

  modport master (
    output cacc2sdp_valid, cacc2sdp_pd, sdp_dp_ready,
    input  cacc2sdp_ready, sdp_dp_valid, sdp_dp_data, sdp_dp_last,
           sdp_dp_batch_end, sdp_dp_layer_end, sdp_layer_done, rx_idle
  );

endinterface

// File: rtl/sdp_cacc2sdp_rx_fifo.sv
// DEPTH-entry synchronous FIFO holding whole accumulator lines; head is read
// straight from registered storage, so a push is visible one cycle later.
module sdp_cacc_rx_fifo
  import sdp_cacc_rx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CACC2SDP_PD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rdPtr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/sdp_cacc2sdp_rx.sv
// SDP receiver for the CACC output stream: buffers lines and unpacks them into beats.
// Define SDP_CACC_RX_PERF_EN to add saturating stall/line performance counters.
module sdp_cacc2sdp_rx
  import sdp_cacc_rx_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int OUT_ELEMS = 4
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rst,
  sdp_cacc2sdp_rx_if.slave     rx
`ifdef SDP_CACC_RX_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_line_cnt
`endif
);

  localparam int NBEATS  = beatsPerLine(OUT_ELEMS);
  localparam int SLICE_W = ELEM_W * OUT_ELEMS;
  localparam int BW      = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

  logic [CACC2SDP_PD_W-1:0]        w_headRaw;
  cacc2sdp_pd_t                    w_head;
  logic [NBEATS-1:0][SLICE_W-1:0]  w_slices;
  logic                            w_full;
  logic                            w_empty;
  logic                            w_push;
  logic                            w_fire;
  logic                            w_last;
  logic                            w_pop;
  logic [BW-1:0]                   r_beatCnt;
  logic                            r_layerDone;

  sdp_cacc_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CACC2SDP_PD_W)
  ) u_fifo (
    .clk     (nvdla_core_clk),
    .rst     (nvdla_core_rst),
    .i_push  (w_push),
    .i_data  (rx.cacc2sdp_pd),
    .i_pop   (w_pop),
    .o_data  (w_headRaw),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Ready follows the registered fill level only; held low while reset is applied.
  assign rx.cacc2sdp_ready = !w_full && !nvdla_core_rst;
  assign w_push            = rx.cacc2sdp_valid && rx.cacc2sdp_ready;

  assign w_head   = cacc2sdp_pd_t'(w_headRaw);
  assign w_slices = w_head.elems;
  assign w_last   = (r_beatCnt == LAST_BEAT);
  assign w_fire   = !w_empty && rx.sdp_dp_ready;
  assign w_pop    = w_fire && w_last;

  assign rx.sdp_dp_valid     = !w_empty;
  assign rx.sdp_dp_data      = w_slices[r_beatCnt];
  assign rx.sdp_dp_last      = w_last;
  assign rx.sdp_dp_batch_end = w_last && !w_empty && w_head.batchEnd;
  assign rx.sdp_dp_layer_end = w_last && !w_empty && w_head.layerEnd;
  assign rx.sdp_layer_done   = r_layerDone;
  assign rx.rx_idle          = w_empty && (r_beatCnt == '0);

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_beatCnt   <= '0;
      r_layerDone <= 1'b0;
    end else begin
      if (w_fire) r_beatCnt <= w_last ? '0 : r_beatCnt + BW'(1);
      r_layerDone <= w_pop && w_head.layerEnd;
    end
  end

`ifdef SDP_CACC_RX_PERF_EN
  logic [31:0] r_stallCnt;
  logic [31:0] r_lineCnt;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_stallCnt <= '0;
      r_lineCnt  <= '0;
    end else begin
      if (rx.cacc2sdp_valid && !rx.cacc2sdp_ready && (r_stallCnt != '1))
        r_stallCnt <= r_stallCnt + 32'd1;
      if (w_pop && (r_lineCnt != '1))
        r_lineCnt <= r_lineCnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_stallCnt;
  assign perf_line_cnt  = r_lineCnt;
`endif

endmodule

// File: tb/tb_sdp_cacc2sdp_rx.sv
// Randomised self-checking bench for sdp_cacc2sdp_rx against a beat-queue model.
// Perf counter checks run when SDP_CACC_RX_PERF_EN is defined.
module tb_sdp_cacc2sdp_rx;
  import sdp_cacc_rx_pkg::*;

  localparam int DEPTH     = 4;
  localparam int OUT_ELEMS = 4;
  localparam int NBEATS    = 16 / OUT_ELEMS;
  localparam int SLICE_W   = 32 * OUT_ELEMS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdp_cacc2sdp_rx_if #(.OUT_ELEMS(OUT_ELEMS)) rxIf ();

`ifdef SDP_CACC_RX_PERF_EN
  logic [31:0] perfStall;
  logic [31:0] perfLine;
`endif

  sdp_cacc2sdp_rx #(.DEPTH(DEPTH), .OUT_ELEMS(OUT_ELEMS)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .rx             (rxIf.slave)
`ifdef SDP_CACC_RX_PERF_EN
    ,
    .perf_stall_cnt (perfStall),
    .perf_line_cnt  (perfLine)
`endif
  );

  typedef struct {
    logic [SLICE_W-1:0] data;
    logic               last;
    logic               batchEnd;
    logic               layerEnd;
  } beat_t;

  beat_t expQ[$];
  logic  expDone;
  int    nVec;
  int    nMiss;

  function automatic logic [CACC2SDP_PD_W-1:0] randLine();
    logic [CACC2SDP_PD_W-1:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
    l[512] = 1'($urandom_range(0, 1));
    l[513] = 1'($urandom_range(0, 1));
    return l;
  endfunction

  // A line becomes NBEATS beats, lowest elements first; flags ride only the final beat.
  function automatic void pushLine(input logic [CACC2SDP_PD_W-1:0] l);
    beat_t b;
    for (int k = 0; k < NBEATS; k++) begin
      b.data     = l[k*SLICE_W +: SLICE_W];
      b.last     = (k == NBEATS - 1);
      b.batchEnd = b.last ? l[512] : 1'b0;
      b.layerEnd = b.last ? l[513] : 1'b0;
      expQ.push_back(b);
    end
  endfunction

  function automatic int linesHeld();
    return (expQ.size() + NBEATS - 1) / NBEATS;
  endfunction

  // Drives one cycle (entered at posedge+1), compares outputs against the model, then advances it.
  task automatic step(input logic inValid, input logic [CACC2SDP_PD_W-1:0] inPd,
                      input logic outReady, output logic accepted);
    logic  expValid;
    logic  expReady;
    beat_t fr;
    rxIf.cacc2sdp_valid = inValid;
    rxIf.cacc2sdp_pd    = inPd;
    rxIf.sdp_dp_ready   = outReady;
    expValid = (expQ.size() != 0);
    expReady = (linesHeld() != DEPTH);
    #1;
    nVec++; if (rxIf.cacc2sdp_ready !== expReady) begin nMiss++; $display("[TB] FAIL in_ready: got %b want %b t=%0t", rxIf.cacc2sdp_ready, expReady, $time); end
    nVec++; if (rxIf.sdp_dp_valid !== expValid) begin nMiss++; $display("[TB] FAIL dp_valid: got %b want %b t=%0t", rxIf.sdp_dp_valid, expValid, $time); end
    nVec++; if (rxIf.rx_idle !== !expValid) begin nMiss++; $display("[TB] FAIL rx_idle: got %b want %b t=%0t", rxIf.rx_idle, !expValid, $time); end
    nVec++; if (rxIf.sdp_layer_done !== expDone) begin nMiss++; $display("[TB] FAIL layer_done: got %b want %b t=%0t", rxIf.sdp_layer_done, expDone, $time); end
    if (expValid) begin
      fr = expQ[0];
      nVec++; if (rxIf.sdp_dp_data !== fr.data) begin nMiss++; $display("[TB] FAIL dp_data: got %h want %h t=%0t", rxIf.sdp_dp_data, fr.data, $time); end
      nVec++; if (rxIf.sdp_dp_last !== fr.last) begin nMiss++; $display("[TB] FAIL dp_last: got %b want %b t=%0t", rxIf.sdp_dp_last, fr.last, $time); end
      nVec++; if (rxIf.sdp_dp_batch_end !== fr.batchEnd) begin nMiss++; $display("[TB] FAIL batch_end: got %b want %b t=%0t", rxIf.sdp_dp_batch_end, fr.batchEnd, $time); end
      nVec++; if (rxIf.sdp_dp_layer_end !== fr.layerEnd) begin nMiss++; $display("[TB] FAIL layer_end: got %b want %b t=%0t", rxIf.sdp_dp_layer_end, fr.layerEnd, $time); end
    end
    @(posedge clk);
    accepted = inValid && expReady;
    expDone  = 1'b0;
    if (expValid && outReady) begin
      fr      = expQ.pop_front();
      expDone = fr.last && fr.layerEnd;
    end
    if (accepted) pushLine(inPd);
    #1;
  endtask

  task automatic drainAll(input int maxCycles, input logic randReady);
    logic acc;
    int   c;
    c = 0;
    while (expQ.size() != 0 && c < maxCycles) begin
      step(1'b0, '0, randReady ? 1'($urandom_range(0, 1)) : 1'b1, acc);
      c++;
    end
    step(1'b0, '0, 1'b1, acc);
    nVec++;
    if (expQ.size() != 0) begin nMiss++; $display("[TB] FAIL drain_timeout: got %0d beats left want 0", expQ.size()); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxIf.cacc2sdp_valid = 1'b0;
    rxIf.cacc2sdp_pd    = '0;
    rxIf.sdp_dp_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nVec++; if (rxIf.cacc2sdp_ready !== 1'b0) begin nMiss++; $display("[TB] FAIL rst_in_ready: got %b want 0", rxIf.cacc2sdp_ready); end
    nVec++; if (rxIf.sdp_dp_valid !== 1'b0) begin nMiss++; $display("[TB] FAIL rst_dp_valid: got %b want 0", rxIf.sdp_dp_valid); end
    nVec++; if (rxIf.rx_idle !== 1'b1) begin nMiss++; $display("[TB] FAIL rst_idle: got %b want 1", rxIf.rx_idle); end
    rst = 1'b0;
    #1;
    nVec++; if (rxIf.cacc2sdp_ready !== 1'b1) begin nMiss++; $display("[TB] FAIL post_rst_ready: got %b want 1", rxIf.cacc2sdp_ready); end
    nVec++; if (rxIf.sdp_dp_valid !== 1'b0) begin nMiss++; $display("[TB] FAIL post_rst_valid: got %b want 0", rxIf.sdp_dp_valid); end
    nVec++; if (rxIf.rx_idle !== 1'b1) begin nMiss++; $display("[TB] FAIL post_rst_idle: got %b want 1", rxIf.rx_idle); end
    nVec++; if (rxIf.sdp_layer_done !== 1'b0) begin nMiss++; $display("[TB] FAIL post_rst_done: got %b want 0", rxIf.sdp_layer_done); end
    expQ.delete();
    expDone = 1'b0;
  endtask

  task automatic test_single_line();
    logic [CACC2SDP_PD_W-1:0] l;
    logic [SLICE_W-1:0]       e;
    logic                     acc;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = 32'h100 + 32'(i);
    l[512] = 1'b0;
    l[513] = 1'b1;
    step(1'b1, l, 1'b1, acc);
    for (int b = 0; b < NBEATS; b++) begin
      for (int k = 0; k < OUT_ELEMS; k++) e[32*k +: 32] = 32'h100 + 32'(b*OUT_ELEMS + k);
      nVec++; if (rxIf.sdp_dp_data !== e) begin nMiss++; $display("[TB] FAIL single_data%0d: got %h want %h", b, rxIf.sdp_dp_data, e); end
      nVec++; if (rxIf.sdp_dp_last !== (b == NBEATS-1)) begin nMiss++; $display("[TB] FAIL single_last%0d: got %b want %b", b, rxIf.sdp_dp_last, (b == NBEATS-1)); end
      nVec++; if (rxIf.sdp_dp_layer_end !== (b == NBEATS-1)) begin nMiss++; $display("[TB] FAIL single_lend%0d: got %b want %b", b, rxIf.sdp_dp_layer_end, (b == NBEATS-1)); end
      step(1'b0, '0, 1'b1, acc);
    end
    nVec++; if (rxIf.sdp_layer_done !== 1'b1) begin nMiss++; $display("[TB] FAIL single_done: got %b want 1", rxIf.sdp_layer_done); end
    step(1'b0, '0, 1'b1, acc);
  endtask

  task automatic test_backpressure();
    logic [CACC2SDP_PD_W-1:0] l5;
    logic                     acc;
    int                       c;
    for (int k = 0; k < DEPTH; k++) step(1'b1, randLine(), 1'b0, acc);
    nVec++; if (rxIf.cacc2sdp_ready !== 1'b0) begin nMiss++; $display("[TB] FAIL bp_full_ready: got %b want 0", rxIf.cacc2sdp_ready); end
    l5  = randLine();
    acc = 1'b0;
    c   = 0;
    while (!acc && c < 200) begin
      step(1'b1, l5, 1'($urandom_range(0, 1)), acc);
      c++;
    end
    nVec++; if (!acc) begin nMiss++; $display("[TB] FAIL bp_fifth_push: got 0 want 1"); end
    drainAll(400, 1'b1);
  endtask

  task automatic test_push_pop_full();
    logic [CACC2SDP_PD_W-1:0] l;
    logic                     acc;
    for (int k = 0; k < DEPTH; k++) step(1'b1, randLine(), 1'b0, acc);
    l = randLine();
    for (int c = 0; c < 60; c++) begin
      step(1'b1, l, 1'b1, acc);
      if (acc) l = randLine();
    end
    drainAll(200, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [CACC2SDP_PD_W-1:0] l;
    logic                     acc;
    for (int k = 0; k < 3; k++) begin
      l = randLine();
      l[513] = 1'b1;
      step(1'b1, l, 1'b1, acc);
    end
    drainAll(100, 1'b0);
  endtask

  task automatic test_random();
    logic [CACC2SDP_PD_W-1:0] l;
    logic                     acc;
    logic                     v;
    l = randLine();
    v = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (!v) v = 1'($urandom_range(0, 1));
      step(v, l, ($urandom_range(0, 3) != 0), acc);
      if (acc) begin
        l = randLine();
        v = 1'b0;
      end
    end
    drainAll(300, 1'b1);
  endtask

  task automatic test_midline_reset();
    logic acc;
    for (int k = 0; k < 3; k++) step(1'b1, randLine(), 1'b0, acc);
    step(1'b0, '0, 1'b1, acc);
    step(1'b0, '0, 1'b1, acc);
    rst = 1'b1;
    rxIf.cacc2sdp_valid = 1'b1;
    rxIf.cacc2sdp_pd    = randLine();
    rxIf.sdp_dp_ready   = 1'b1;
    @(posedge clk);
    #1;
    nVec++; if (rxIf.sdp_dp_valid !== 1'b0) begin nMiss++; $display("[TB] FAIL mid_rst_valid: got %b want 0", rxIf.sdp_dp_valid); end
    nVec++; if (rxIf.rx_idle !== 1'b1) begin nMiss++; $display("[TB] FAIL mid_rst_idle: got %b want 1", rxIf.rx_idle); end
    nVec++; if (rxIf.cacc2sdp_ready !== 1'b0) begin nMiss++; $display("[TB] FAIL mid_rst_ready: got %b want 0", rxIf.cacc2sdp_ready); end
    nVec++; if (rxIf.sdp_layer_done !== 1'b0) begin nMiss++; $display("[TB] FAIL mid_rst_done: got %b want 0", rxIf.sdp_layer_done); end
    rst = 1'b0;
    expQ.delete();
    expDone = 1'b0;
    for (int c = 0; c < 5; c++) step(1'b0, '0, 1'b1, acc);
    step(1'b1, randLine(), 1'b1, acc);
    drainAll(50, 1'b0);
  endtask

`ifdef SDP_CACC_RX_PERF_EN
  task automatic test_perf();
    logic acc;
    test_reset();
    for (int k = 0; k < DEPTH; k++) step(1'b1, randLine(), 1'b0, acc);
    for (int k = 0; k < 10; k++) step(1'b1, randLine(), 1'b0, acc);
    nVec++; if (perfStall !== 32'd10) begin nMiss++; $display("[TB] FAIL perf_stall: got %0d want 10", perfStall); end
    drainAll(100, 1'b0);
    nVec++; if (perfLine !== 32'(DEPTH)) begin nMiss++; $display("[TB] FAIL perf_line: got %0d want %0d", perfLine, DEPTH); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nVec    = 0;
    nMiss   = 0;
    expDone = 1'b0;
    test_reset();
    test_single_line();
    test_backpressure();
    test_push_pop_full();
    test_back_to_back();
    test_random();
    test_midline_reset();
`ifdef SDP_CACC_RX_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
